// File: rtl/fusion_stream_pkg.sv
// Shared definitions for the fused-frame streaming path: default widths,
// header field layout and the serializer state encoding.
package fusion_stream_pkg;

    localparam int DEF_BEAT_W    = 256;
    localparam int DEF_FRAME_W   = 3840;
    localparam int NUM_BEATS_DEF = DEF_FRAME_W / DEF_BEAT_W;

    localparam int TS_W   = 64;
    localparam int SEQ_W  = 32;

    localparam int HDR_TS_LSB  = 0;
    localparam int HDR_SEQ_LSB = 64;
    localparam int HDR_ERR_BIT = 96;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        PAYLOAD = 2'd2
    } state_t;

endpackage

// File: rtl/fused_frame_slot.sv
// One frame buffer: payload, timestamp, error flag and sequence number.
// Only the occupancy flag is reset; the data registers are load-enabled.
module fused_frame_slot
    import fusion_stream_pkg::*;
#(
    parameter int FRAME_W = DEF_FRAME_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               clear,
    input  logic [FRAME_W-1:0] load_frame,
    input  logic [TS_W-1:0]    load_ts,
    input  logic               load_err,
    input  logic [SEQ_W-1:0]   load_seq,
    output logic               full,
    output logic [FRAME_W-1:0] frame,
    output logic [TS_W-1:0]    ts,
    output logic               err,
    output logic [SEQ_W-1:0]   seq
);

    // A load in the same cycle as a clear keeps the slot occupied.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            full <= 1'b0;
        else if (load)
            full <= 1'b1;
        else if (clear)
            full <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (load) begin
            frame <= load_frame;
            ts    <= load_ts;
            err   <= load_err;
            seq   <= load_seq;
        end
    end

endmodule

// File: rtl/fused_frame_serializer.sv
// Serializes aligned fused frames into a header beat plus payload beats,
// with one pending slot to absorb a frame arriving mid-transmission.
module fused_frame_serializer
    import fusion_stream_pkg::*;
#(
    parameter int BEAT_W  = DEF_BEAT_W,
    parameter int FRAME_W = DEF_FRAME_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [FRAME_W-1:0] fused_data,
    input  logic               fused_valid,
    input  logic               align_error,
    input  logic [63:0]        t_common,
    input  logic               clr_stats,
    input  logic               m_ready,
    output logic               m_valid,
    output logic [BEAT_W-1:0]  m_data,
    output logic               m_first,
    output logic               m_last,
    output logic               busy,
    output logic [15:0]        drop_count,
    output logic               overflow
);

    localparam int NUM_BEATS = FRAME_W / BEAT_W;
    localparam int CNT_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   beat_cnt;
    logic [SEQ_W-1:0]   seq_cnt;

    logic               a_full, p_full;
    logic [FRAME_W-1:0] a_frame, p_frame;
    logic [TS_W-1:0]    a_ts, p_ts;
    logic               a_err, p_err;
    logic [SEQ_W-1:0]   a_seq, p_seq;

    logic               last_xfer, drop, accept;
    logic               a_load, a_from_p, a_clear, p_load, p_clear;
    logic [BEAT_W-1:0]  hdr;

    // A frame arriving on the last-beat transfer never drops: the pending
    // slot is vacated in that same cycle.
    assign last_xfer = (state == PAYLOAD) && (beat_cnt == LAST_BEAT) && m_ready;
    assign drop      = fused_valid && a_full && p_full && !last_xfer;
    assign accept    = fused_valid && !drop;
    assign a_from_p  = last_xfer && p_full;
    assign a_load    = (fused_valid && !a_full) || (last_xfer && (p_full || fused_valid));
    assign a_clear   = last_xfer && !a_load;
    assign p_load    = fused_valid && a_full && ((last_xfer && p_full) || (!last_xfer && !p_full));
    assign p_clear   = a_from_p;

    fused_frame_slot #(.FRAME_W(FRAME_W)) u_active (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (a_load),
        .clear      (a_clear),
        .load_frame (a_from_p ? p_frame : fused_data),
        .load_ts    (a_from_p ? p_ts    : t_common),
        .load_err   (a_from_p ? p_err   : align_error),
        .load_seq   (a_from_p ? p_seq   : seq_cnt),
        .full       (a_full),
        .frame      (a_frame),
        .ts         (a_ts),
        .err        (a_err),
        .seq        (a_seq)
    );

    fused_frame_slot #(.FRAME_W(FRAME_W)) u_pending (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (p_load),
        .clear      (p_clear),
        .load_frame (fused_data),
        .load_ts    (t_common),
        .load_err   (align_error),
        .load_seq   (seq_cnt),
        .full       (p_full),
        .frame      (p_frame),
        .ts         (p_ts),
        .err        (p_err),
        .seq        (p_seq)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (a_load)    state_nxt = HEADER;
            HEADER:  if (m_ready)   state_nxt = PAYLOAD;
            PAYLOAD: if (last_xfer) state_nxt = a_load ? HEADER : IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
        end else if (state == PAYLOAD && m_ready) begin
            beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            seq_cnt <= '0;
        else if (accept)
            seq_cnt <= seq_cnt + 1'b1;
    end

    // A drop coinciding with a clear is counted after the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_count <= '0;
            overflow   <= 1'b0;
        end else if (clr_stats) begin
            drop_count <= drop ? 16'd1 : 16'd0;
            overflow   <= drop;
        end else if (drop) begin
            if (drop_count != 16'hFFFF)
                drop_count <= drop_count + 16'd1;
            overflow <= 1'b1;
        end
    end

    always_comb begin
        hdr = '0;
        hdr[HDR_TS_LSB +: TS_W]   = a_ts;
        hdr[HDR_SEQ_LSB +: SEQ_W] = a_seq;
        hdr[HDR_ERR_BIT]          = a_err;
        m_data = '0;
        case (state)
            HEADER:  m_data = hdr;
            PAYLOAD: m_data = a_frame[int'(beat_cnt) * BEAT_W +: BEAT_W];
            default: m_data = '0;
        endcase
    end

    assign m_valid = (state != IDLE);
    assign m_first = (state == HEADER);
    assign m_last  = (state == PAYLOAD) && (beat_cnt == LAST_BEAT);
    assign busy    = (state != IDLE) || p_full;

endmodule

// File: tb/tb_fused_frame_serializer.sv
// Directed bench for fused_frame_serializer: single frames, stalls,
// back-to-back frames, drops, stats clear and mid-frame reset.
module tb_fused_frame_serializer;

    localparam int BEAT_W  = 256;
    localparam int FRAME_W = 3840;
    localparam int NB      = FRAME_W / BEAT_W;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [FRAME_W-1:0] fused_data;
    logic               fused_valid;
    logic               align_error;
    logic [63:0]        t_common;
    logic               clr_stats;
    logic               m_ready;
    logic               m_valid;
    logic [BEAT_W-1:0]  m_data;
    logic               m_first;
    logic               m_last;
    logic               busy;
    logic [15:0]        drop_count;
    logic               overflow;

    int checks = 0;
    int errors = 0;

    fused_frame_serializer #(.BEAT_W(BEAT_W), .FRAME_W(FRAME_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fused_data  (fused_data),
        .fused_valid (fused_valid),
        .align_error (align_error),
        .t_common    (t_common),
        .clr_stats   (clr_stats),
        .m_ready     (m_ready),
        .m_valid     (m_valid),
        .m_data      (m_data),
        .m_first     (m_first),
        .m_last      (m_last),
        .busy        (busy),
        .drop_count  (drop_count),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [FRAME_W-1:0] mk(input int base);
        logic [FRAME_W-1:0] f;
        f = '0;
        for (int k = 0; k < NB; k++)
            f[k*BEAT_W +: BEAT_W] = {32{8'(k + base)}};
        return f;
    endfunction

    function automatic logic [255:0] hdr_of(input logic [63:0] ts, input logic [31:0] sq, input logic er);
        logic [255:0] h;
        h = '0;
        h[63:0]  = ts;
        h[95:64] = sq;
        h[96]    = er;
        return h;
    endfunction

    task automatic strobe(input logic [FRAME_W-1:0] f, input logic [63:0] ts, input logic er);
        fused_data  = f;
        t_common    = ts;
        align_error = er;
        fused_valid = 1'b1;
        tick();
        fused_valid = 1'b0;
    endtask

    // Beat 0 is the header, beats 1..NB are payload. Every beat is expected
    // to be presented without a gap; alt inserts a stall cycle before each transfer.
    task automatic recv(input string nm, input logic [63:0] ts, input logic [31:0] sq, input logic er,
                        input logic [FRAME_W-1:0] f, input int first, input int last, input bit alt);
        logic [255:0] exp;
        for (int b = first; b <= last; b++) begin
            exp = (b == 0) ? hdr_of(ts, sq, er) : f[(b-1)*BEAT_W +: BEAT_W];
            check($sformatf("%s_valid_b%0d", nm, b), m_valid, 1'b1);
            check($sformatf("%s_data_b%0d", nm, b), m_data, exp);
            check($sformatf("%s_first_b%0d", nm, b), m_first, b == 0);
            check($sformatf("%s_last_b%0d", nm, b), m_last, b == NB);
            if (alt) begin
                m_ready = 1'b0;
                tick();
                check($sformatf("%s_stall_valid_b%0d", nm, b), m_valid, 1'b1);
                check($sformatf("%s_stall_data_b%0d", nm, b), m_data, exp);
                check($sformatf("%s_stall_fl_b%0d", nm, b), {m_first, m_last}, {b == 0, b == NB});
            end
            m_ready = 1'b1;
            tick();
        end
    endtask

    logic [FRAME_W-1:0] fr [0:12];

    initial begin
        for (int i = 0; i < 13; i++) fr[i] = mk(i * 16);
        rst_n = 1'b0; fused_data = '0; fused_valid = 1'b0; align_error = 1'b0;
        t_common = '0; clr_stats = 1'b0; m_ready = 1'b0;
        tick(); tick();
        check("rst_valid", m_valid, 1'b0);
        check("rst_first_last", {m_first, m_last}, 2'b00);
        check("rst_data", m_data, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_drops", drop_count, 16'd0);
        check("rst_overflow", overflow, 1'b0);
        rst_n = 1'b1;
        tick();

        // single frame, always ready
        m_ready = 1'b1;
        strobe(fr[0], 64'h1234, 1'b0);
        recv("f0", 64'h1234, 32'd0, 1'b0, fr[0], 0, NB, 1'b0);
        check("f0_done_valid", m_valid, 1'b0);
        check("f0_done_busy", busy, 1'b0);

        // alternating ready
        strobe(fr[1], 64'hDEAD_BEEF_0000_0055, 1'b1);
        recv("f1", 64'hDEAD_BEEF_0000_0055, 32'd1, 1'b1, fr[1], 0, NB, 1'b1);
        check("f1_done_valid", m_valid, 1'b0);

        // second strobe 3 cycles after the first
        strobe(fr[2], 64'h22, 1'b0);
        recv("f2a", 64'h22, 32'd2, 1'b0, fr[2], 0, 1, 1'b0);
        strobe(fr[3], 64'h33, 1'b0);
        check("f3_pending_busy", busy, 1'b1);
        recv("f2b", 64'h22, 32'd2, 1'b0, fr[2], 3, NB, 1'b0);
        recv("f3", 64'h33, 32'd3, 1'b0, fr[3], 0, NB, 1'b0);
        check("f3_done_valid", m_valid, 1'b0);

        // overflow with downstream stalled
        m_ready = 1'b0;
        strobe(fr[4], 64'h44, 1'b0);
        strobe(fr[5], 64'h55, 1'b1);
        strobe(fr[6], 64'h66, 1'b0);
        check("drop_count_1", drop_count, 16'd1);
        check("overflow_1", overflow, 1'b1);
        check("drop_busy", busy, 1'b1);
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        check("clr_drop_count", drop_count, 16'd0);
        check("clr_overflow", overflow, 1'b0);
        clr_stats = 1'b1;
        strobe(fr[6], 64'h66, 1'b0);
        clr_stats = 1'b0;
        check("clr_drop_same_count", drop_count, 16'd1);
        check("clr_drop_same_ovf", overflow, 1'b1);
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        check("clr2_drop_count", drop_count, 16'd0);
        recv("f4", 64'h44, 32'd4, 1'b0, fr[4], 0, NB, 1'b0);
        recv("f5", 64'h55, 32'd5, 1'b1, fr[5], 0, NB, 1'b0);
        check("f5_done_valid", m_valid, 1'b0);

        // strobe on last-beat transfer, pending full then pending empty
        strobe(fr[7], 64'h77, 1'b0);
        recv("f7a", 64'h77, 32'd6, 1'b0, fr[7], 0, 3, 1'b0);
        strobe(fr[8], 64'h88, 1'b0);
        recv("f7b", 64'h77, 32'd6, 1'b0, fr[7], 5, NB - 1, 1'b0);
        check("f7_last_shown", m_last, 1'b1);
        strobe(fr[9], 64'h99, 1'b0);
        check("f9_no_drop", drop_count, 16'd0);
        recv("f8", 64'h88, 32'd7, 1'b0, fr[8], 0, NB, 1'b0);
        recv("f9a", 64'h99, 32'd8, 1'b0, fr[9], 0, NB - 1, 1'b0);
        strobe(fr[10], 64'hAA, 1'b1);
        recv("f10", 64'hAA, 32'd9, 1'b1, fr[10], 0, NB, 1'b0);
        check("f10_done_valid", m_valid, 1'b0);
        check("f10_no_drop", {overflow, drop_count}, 17'd0);

        // reset in the middle of payload beat 7 with a pending frame
        strobe(fr[11], 64'hBB, 1'b0);
        recv("f11", 64'hBB, 32'd10, 1'b0, fr[11], 0, 2, 1'b0);
        strobe(fr[12], 64'hCC, 1'b0);
        recv("f11b", 64'hBB, 32'd10, 1'b0, fr[11], 4, 7, 1'b0);
        check("f11_pl7_data", m_data, fr[11][7*BEAT_W +: BEAT_W]);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", m_valid, 1'b0);
        check("midrst_busy", busy, 1'b0);
        tick();
        rst_n = 1'b1;
        tick(); tick();
        check("postrst_valid", m_valid, 1'b0);
        check("postrst_busy", busy, 1'b0);
        strobe(fr[0], 64'h0F0F, 1'b0);
        recv("post", 64'h0F0F, 32'd0, 1'b0, fr[0], 0, NB, 1'b0);
        check("post_done_valid", m_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
